// File: rtl/icache_fill_arbiter_if.sv
// rtl/icache_fill_arbiter_if.sv - miss/bus/fill signal bundle for the I$ fill arbiter
interface icache_fill_arbiter_if;
  logic        miss_e;
  logic [14:0] paddr_e;
  logic        miss_o;
  logic [14:0] paddr_o;
  logic        flush;
  logic        grant;
  logic        ack;
  logic        fill_e;
  logic        fill_o;
  logic        accept_e;
  logic        accept_o;
  logic        req;
  logic        bus_release;
  logic        ser_valid;
  logic [14:0] ser_paddr;
  logic [3:0]  ser_return;
  logic        ser_rw;
  logic [15:0] ser_size;
  logic        busy;
  logic        fill_err;

  modport master (
    input  miss_e, paddr_e, miss_o, paddr_o, flush, grant, ack, fill_e, fill_o,
    output accept_e, accept_o, req, bus_release, ser_valid, ser_paddr,
           ser_return, ser_rw, ser_size, busy, fill_err
  );

  modport slave (
    output miss_e, paddr_e, miss_o, paddr_o, flush, grant, ack, fill_e, fill_o,
    input  accept_e, accept_o, req, bus_release, ser_valid, ser_paddr,
           ser_return, ser_rw, ser_size, busy, fill_err
  );
endinterface

// File: rtl/icache_fill_arbiter.sv
// rtl/icache_fill_arbiter.sv - round-robin even/odd I$ miss arbiter for the shared BAU request channel
module icache_fill_arbiter #(
  parameter int XFER_BEATS   = 2,
  parameter int FILL_TIMEOUT = 255,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  icache_fill_arbiter_if.master bus
);
  localparam logic [3:0] LAST_BEAT = 4'(XFER_BEATS - 1);
  localparam logic [7:0] TMO_LAST  = 8'(FILL_TIMEOUT - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, REQ, XFER, WAIT_ACK, WAIT_FILL} state_t;

  state_t      state;
  logic [3:0]  beat;
  logic [7:0]  tcnt;
  logic [2:0]  retry;
  logic        ptr_odd;
  logic        sel_odd;
  logic [14:0] paddr_q;
  logic        accept_e_q;
  logic        accept_o_q;
  logic        req_q;
  logic        rel_q;
  logic        valid_q;
  logic        busy_q;
  logic        err_q;
  logic        pick_odd;
  logic        fill_sel;

  // Odd wins when it is the only requester, or when both request and the pointer names odd.
  always_comb begin
    pick_odd = bus.miss_o && (!bus.miss_e || ptr_odd);
    fill_sel = sel_odd ? bus.fill_o : bus.fill_e;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat       <= '0;
      tcnt       <= '0;
      retry      <= '0;
      ptr_odd    <= 1'b0;
      sel_odd    <= 1'b0;
      paddr_q    <= '0;
      accept_e_q <= 1'b0;
      accept_o_q <= 1'b0;
      req_q      <= 1'b0;
      rel_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      accept_e_q <= 1'b0;
      accept_o_q <= 1'b0;
      rel_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.flush && (bus.miss_e || bus.miss_o)) begin
            if (bus.miss_e && bus.miss_o) ptr_odd <= ~ptr_odd;
            sel_odd    <= pick_odd;
            paddr_q    <= pick_odd ? bus.paddr_o : bus.paddr_e;
            accept_e_q <= !pick_odd;
            accept_o_q <= pick_odd;
            req_q      <= 1'b1;
            busy_q     <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.flush) begin
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            retry  <= '0;
            state  <= IDLE;
          end else if (bus.grant) begin
            beat    <= '0;
            valid_q <= 1'b1;
            rel_q   <= (XFER_BEATS == 1);
            state   <= XFER;
          end
        end
        XFER: begin
          if (beat == LAST_BEAT) begin
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            tcnt    <= '0;
            state   <= WAIT_ACK;
          end else begin
            beat  <= beat + 4'd1;
            rel_q <= (beat + 4'd1 == LAST_BEAT);
          end
        end
        WAIT_ACK, WAIT_FILL: begin
          if (state == WAIT_ACK && bus.ack) begin
            tcnt  <= '0;
            state <= WAIT_FILL;
          end else if (state == WAIT_FILL && fill_sel) begin
            busy_q <= 1'b0;
            retry  <= '0;
            state  <= IDLE;
          end else if (tcnt == TMO_LAST) begin
            // Retry reuses the latched paddr/return id; exhaustion drops the miss.
            tcnt <= '0;
            if (retry < RETRY_MAX) begin
              retry <= retry + 3'd1;
              req_q <= 1'b1;
              state <= REQ;
            end else begin
              err_q  <= 1'b1;
              retry  <= '0;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.accept_e    = accept_e_q;
  assign bus.accept_o    = accept_o_q;
  assign bus.req         = req_q;
  assign bus.bus_release = rel_q;
  assign bus.ser_valid   = valid_q;
  assign bus.ser_paddr   = paddr_q;
  assign bus.ser_return  = {3'b000, sel_odd};
  assign bus.ser_rw      = 1'b0;
  assign bus.ser_size    = 16'd16;
  assign bus.busy        = busy_q;
  assign bus.fill_err    = err_q;
endmodule

// File: tb/tb_icache_fill_arbiter.sv
// tb/tb_icache_fill_arbiter.sv - directed self-checking bench for icache_fill_arbiter
module tb_icache_fill_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  icache_fill_arbiter_if bus ();

  icache_fill_arbiter #(
    .XFER_BEATS  (2),
    .FILL_TIMEOUT(8),
    .MAX_RETRY   (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives an accepted request (arbiter in REQ) through grant, transfer, ack and fill.
  task automatic finish_txn(input logic odd);
    bus.grant = 1'b1;
    step();
    bus.grant = 1'b0;
    check("txn_valid_beat0", 32'(bus.ser_valid), 32'd1);
    step();
    check("txn_release", 32'(bus.bus_release), 32'd1);
    step();
    check("txn_valid_done", 32'(bus.ser_valid), 32'd0);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    if (odd) bus.fill_o = 1'b1;
    else     bus.fill_e = 1'b1;
    step();
    bus.fill_e = 1'b0;
    bus.fill_o = 1'b0;
    check("txn_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.miss_e = 1'b0;
    bus.paddr_e = '0;
    bus.miss_o = 1'b0;
    bus.paddr_o = '0;
    bus.flush = 1'b0;
    bus.grant = 1'b0;
    bus.ack = 1'b0;
    bus.fill_e = 1'b0;
    bus.fill_o = 1'b0;

    #22;
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.ser_valid), 32'd0);
    check("rst_err", 32'(bus.fill_err), 32'd0);
    check("rst_paddr", 32'(bus.ser_paddr), 32'd0);
    check("rst_size", 32'(bus.ser_size), 32'd16);
    reset = 1'b1;
    step();

    // Single even miss with delayed grant, ack and fill.
    bus.miss_e = 1'b1;
    bus.paddr_e = 15'h1A40;
    step();
    check("s1_accept_e", 32'(bus.accept_e), 32'd1);
    check("s1_req", 32'(bus.req), 32'd1);
    check("s1_busy", 32'(bus.busy), 32'd1);
    check("s1_paddr", 32'(bus.ser_paddr), 32'h1A40);
    check("s1_return", 32'(bus.ser_return), 32'd0);
    check("s1_rw", 32'(bus.ser_rw), 32'd0);
    bus.miss_e = 1'b0;
    step();
    check("s1_accept_pulse", 32'(bus.accept_e), 32'd0);
    check("s1_req_hold", 32'(bus.req), 32'd1);
    step();
    step();
    bus.grant = 1'b1;
    step();
    bus.grant = 1'b0;
    check("s1_valid0", 32'(bus.ser_valid), 32'd1);
    check("s1_rel0", 32'(bus.bus_release), 32'd0);
    step();
    check("s1_valid1", 32'(bus.ser_valid), 32'd1);
    check("s1_rel1", 32'(bus.bus_release), 32'd1);
    check("s1_req_xfer", 32'(bus.req), 32'd1);
    step();
    check("s1_valid_off", 32'(bus.ser_valid), 32'd0);
    check("s1_rel_off", 32'(bus.bus_release), 32'd0);
    check("s1_req_off", 32'(bus.req), 32'd0);
    step();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    repeat (4) step();
    check("s1_wait_fill", 32'(bus.busy), 32'd1);
    bus.fill_e = 1'b1;
    step();
    bus.fill_e = 1'b0;
    check("s1_done", 32'(bus.busy), 32'd0);
    check("s1_err", 32'(bus.fill_err), 32'd0);

    // Both banks missing on three transactions: even, odd, even.
    bus.paddr_e = 15'h0111;
    bus.paddr_o = 15'h0222;
    for (int k = 0; k < 3; k++) begin
      logic exp_odd;
      exp_odd = (k == 1);
      bus.miss_e = 1'b1;
      bus.miss_o = 1'b1;
      step();
      check("rr_accept_e", 32'(bus.accept_e), 32'(!exp_odd));
      check("rr_accept_o", 32'(bus.accept_o), 32'(exp_odd));
      check("rr_return", 32'(bus.ser_return), 32'(exp_odd));
      check("rr_paddr", 32'(bus.ser_paddr), exp_odd ? 32'h0222 : 32'h0111);
      if (exp_odd) bus.miss_o = 1'b0;
      else         bus.miss_e = 1'b0;
      finish_txn(exp_odd);
      bus.miss_e = 1'b0;
      bus.miss_o = 1'b0;
    end

    // Flush in IDLE blocks selection.
    bus.miss_e = 1'b1;
    bus.paddr_e = 15'h0055;
    bus.flush = 1'b1;
    step();
    check("fl_idle_block", 32'(bus.accept_e), 32'd0);
    check("fl_idle_busy", 32'(bus.busy), 32'd0);
    bus.flush = 1'b0;
    step();
    check("fl_accept", 32'(bus.accept_e), 32'd1);
    bus.miss_e = 1'b0;
    // Flush and grant together in REQ: flush wins.
    bus.flush = 1'b1;
    bus.grant = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.grant = 1'b0;
    check("fl_req_drop", 32'(bus.req), 32'd0);
    check("fl_no_valid", 32'(bus.ser_valid), 32'd0);
    check("fl_no_rel", 32'(bus.bus_release), 32'd0);
    check("fl_no_reaccept", 32'(bus.accept_e), 32'd0);
    check("fl_busy", 32'(bus.busy), 32'd0);
    bus.miss_o = 1'b1;
    bus.paddr_o = 15'h7FFF;
    step();
    check("fl_next_accept_o", 32'(bus.accept_o), 32'd1);
    check("fl_next_paddr", 32'(bus.ser_paddr), 32'h7FFF);
    check("fl_next_return", 32'(bus.ser_return), 32'd1);
    bus.miss_o = 1'b0;
    finish_txn(1'b1);

    // Fill timeout with one retry, then error.
    bus.miss_e = 1'b1;
    bus.paddr_e = 15'h0ABC;
    step();
    bus.miss_e = 1'b0;
    for (int r = 0; r < 2; r++) begin
      bus.grant = 1'b1;
      step();
      bus.grant = 1'b0;
      step();
      step();
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      repeat (7) step();
      check("to_waiting", 32'(bus.req), 32'd0);
      check("to_waiting_busy", 32'(bus.busy), 32'd1);
      step();
      if (r == 0) begin
        check("to_retry_req", 32'(bus.req), 32'd1);
        check("to_retry_paddr", 32'(bus.ser_paddr), 32'h0ABC);
        check("to_retry_noerr", 32'(bus.fill_err), 32'd0);
      end else begin
        check("to_err", 32'(bus.fill_err), 32'd1);
        check("to_err_idle", 32'(bus.busy), 32'd0);
        check("to_err_req", 32'(bus.req), 32'd0);
      end
    end

    // Fill of the other bank is ignored.
    bus.miss_e = 1'b1;
    bus.paddr_e = 15'h1234;
    step();
    bus.miss_e = 1'b0;
    bus.grant = 1'b1;
    step();
    bus.grant = 1'b0;
    step();
    step();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    bus.fill_o = 1'b1;
    step();
    bus.fill_o = 1'b0;
    check("fo_ignored", 32'(bus.busy), 32'd1);
    bus.fill_e = 1'b1;
    step();
    bus.fill_e = 1'b0;
    check("fo_fill_e_idle", 32'(bus.busy), 32'd0);
    check("fo_err_sticky", 32'(bus.fill_err), 32'd1);

    // Asynchronous reset mid-transfer; pointer currently names odd.
    bus.miss_e = 1'b1;
    bus.miss_o = 1'b1;
    bus.paddr_e = 15'h0333;
    bus.paddr_o = 15'h0444;
    step();
    check("ar_pre_accept_o", 32'(bus.accept_o), 32'd1);
    bus.miss_e = 1'b0;
    bus.miss_o = 1'b0;
    bus.grant = 1'b1;
    step();
    bus.grant = 1'b0;
    check("ar_in_xfer", 32'(bus.ser_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req", 32'(bus.req), 32'd0);
    check("ar_valid", 32'(bus.ser_valid), 32'd0);
    check("ar_rel", 32'(bus.bus_release), 32'd0);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_err", 32'(bus.fill_err), 32'd0);
    check("ar_paddr", 32'(bus.ser_paddr), 32'd0);
    check("ar_return", 32'(bus.ser_return), 32'd0);
    step();
    reset = 1'b1;
    bus.miss_e = 1'b1;
    bus.miss_o = 1'b1;
    step();
    check("ar_ptr_even", 32'(bus.accept_e), 32'd1);
    check("ar_ptr_not_odd", 32'(bus.accept_o), 32'd0);
    check("ar_post_paddr", 32'(bus.ser_paddr), 32'h0333);
    bus.miss_e = 1'b0;
    bus.miss_o = 1'b0;
    finish_txn(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
